dp_ram_pipe: RTL

- Parametrised dual-port synchronous RAM.
- Port A is read/write with byte enables; port B is read-only.
- Adds a configurable read latency, a selectable read-during-write mode on port A, collision flagging on port B, and a hardware clear sequence after reset.
- Serves as the next-generation frame/coefficient store for the video datapath; it replaces the fixed 16/32 RAM.

---
 rtl/dp_ram_pipe_if.sv | 40 ++++
 rtl/dp_ram_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_pipe_if.sv
// Bus bundle for dp_ram_pipe: port A read/write with byte enables, port B
// read-only, and the init_busy status output.
//   master : drives addresses, data, enables; receives read data and status.
//   slave  : the RAM side.
interface dp_ram_pipe_if #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32
);
    logic                     init_busy;

    logic [ADDR_SIZE-1:0]     addr_A;
    logic [DATA_SIZE-1:0]     data_in_A;
    logic [DATA_SIZE/8-1:0]   be_A;
    logic                     w_e_A;
    logic                     r_e_A;
    logic [DATA_SIZE-1:0]     data_out_A;
    logic                     valid_A;

    logic [ADDR_SIZE-1:0]     addr_B;
    logic                     r_e_B;
    logic [DATA_SIZE-1:0]     data_out_B;
    logic                     valid_B;
    logic                     collision_B;

    modport master (
        input  init_busy,
        output addr_A, data_in_A, be_A, w_e_A, r_e_A,
        input  data_out_A, valid_A,
        output addr_B, r_e_B,
        input  data_out_B, valid_B, collision_B
    );

    modport slave (
        output init_busy,
        input  addr_A, data_in_A, be_A, w_e_A, r_e_A,
        output data_out_A, valid_A,
        input  addr_B, r_e_B,
        output data_out_B, valid_B, collision_B
    );
endinterface

// File: rtl/dp_ram_pipe.sv
// Dual-port synchronous RAM with a configurable read pipeline.
//   clk        : clock, all state changes on the rising edge
//   nrst       : asynchronous active-low reset
//   bus.slave  : port A (read/write, byte enables), port B (read-only),
//                init_busy (high while the post-reset clear runs)
// Port A read-during-write returns old (RDW_MODE=0) or merged new (RDW_MODE=1)
// data. A port B read that hits the address port A writes in the same cycle
// returns the old word and raises collision_B alongside its valid_B.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing CLEAR_VALUE to word[clr_cnt]; all accesses ignored
// ST_READY | normal operation
module dp_ram_pipe #(
    parameter int                 ADDR_SIZE      = 8,
    parameter int                 DATA_SIZE      = 32,
    parameter int                 READ_LATENCY   = 1,
    parameter int                 RDW_MODE       = 0,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [DATA_SIZE-1:0] CLEAR_VALUE  = '0
) (
    input  logic         clk,
    input  logic         nrst,
    dp_ram_pipe_if.slave bus
);

    localparam int DEPTH     = 2 ** ADDR_SIZE;
    localparam int NUM_BYTES = DATA_SIZE / 8;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    state_t                 state;
    state_t                 state_nxt;
    logic [ADDR_SIZE-1:0]   clr_cnt;
    logic                   clr_inc;
    logic                   clr_active;

    logic [DATA_SIZE-1:0]   mem [DEPTH];

    logic                   ready;
    logic                   clr_wr;
    logic                   wr_en;
    logic                   rd_en_A;
    logic                   rd_en_B;
    logic                   collide;
    logic [DATA_SIZE-1:0]   old_A;
    logic [DATA_SIZE-1:0]   old_B;
    logic [DATA_SIZE-1:0]   merged_A;
    logic [DATA_SIZE-1:0]   rdata_A;

    // First read stage: the word is captured on the accepting edge.
    logic                   s1_valid_A;
    logic [DATA_SIZE-1:0]   s1_data_A;
    logic                   s1_valid_B;
    logic [DATA_SIZE-1:0]   s1_data_B;
    logic                   s1_coll_B;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_inc) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        clr_inc    = 1'b0;
        clr_active = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_active = 1'b1;
                // The counter parks on the last word instead of wrapping.
                if (&clr_cnt) begin
                    state_nxt = ST_READY;
                end else begin
                    clr_inc = 1'b1;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    assign bus.init_busy = clr_active;

    // ------------------------------------------------------------------
    // Access qualification. nrst gates every enable so nothing reaches the
    // array while reset is held with the clock still running.
    // ------------------------------------------------------------------
    assign ready   = (state == ST_READY) && nrst;
    assign clr_wr  = clr_active && nrst;
    assign wr_en   = ready && bus.w_e_A;
    assign rd_en_A = ready && bus.r_e_A;
    assign rd_en_B = ready && bus.r_e_B;
    // A write with no byte lanes enabled still counts as a collision.
    assign collide = rd_en_B && wr_en && (bus.addr_B == bus.addr_A);

    assign old_A = mem[bus.addr_A];
    assign old_B = mem[bus.addr_B];

    always_comb begin
        merged_A = old_A;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.be_A[i]) begin
                merged_A[8*i +: 8] = bus.data_in_A[8*i +: 8];
            end
        end
    end

    assign rdata_A = (RDW_MODE != 0) ? merged_A : old_A;

    // ------------------------------------------------------------------
    // Storage (no reset: contents are only initialised by the clear pass)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (bus.be_A[i]) begin
                    mem[bus.addr_A][8*i +: 8] <= bus.data_in_A[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1_valid_A <= 1'b0;
            s1_data_A  <= '0;
            s1_valid_B <= 1'b0;
            s1_data_B  <= '0;
            s1_coll_B  <= 1'b0;
        end else begin
            s1_valid_A <= rd_en_A;
            s1_valid_B <= rd_en_B;
            s1_coll_B  <= collide;
            // Data registers only load on a read so the outputs hold.
            if (rd_en_A) begin
                s1_data_A <= rdata_A;
            end
            if (rd_en_B) begin
                s1_data_B <= old_B;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                 s2_valid_A;
            logic [DATA_SIZE-1:0] s2_data_A;
            logic                 s2_valid_B;
            logic [DATA_SIZE-1:0] s2_data_B;
            logic                 s2_coll_B;

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    s2_valid_A <= 1'b0;
                    s2_data_A  <= '0;
                    s2_valid_B <= 1'b0;
                    s2_data_B  <= '0;
                    s2_coll_B  <= 1'b0;
                end else begin
                    s2_valid_A <= s1_valid_A;
                    s2_valid_B <= s1_valid_B;
                    s2_coll_B  <= s1_coll_B;
                    if (s1_valid_A) begin
                        s2_data_A <= s1_data_A;
                    end
                    if (s1_valid_B) begin
                        s2_data_B <= s1_data_B;
                    end
                end
            end

            assign bus.valid_A     = s2_valid_A;
            assign bus.data_out_A  = s2_data_A;
            assign bus.valid_B     = s2_valid_B;
            assign bus.data_out_B  = s2_data_B;
            assign bus.collision_B = s2_coll_B;
        end else begin : g_lat1
            assign bus.valid_A     = s1_valid_A;
            assign bus.data_out_A  = s1_data_A;
            assign bus.valid_B     = s1_valid_B;
            assign bus.data_out_B  = s1_data_B;
            assign bus.collision_B = s1_coll_B;
        end
    endgenerate

endmodule
